riscv_instr_port_arbiter: RTL and testbench
===========================================

# riscv_instr_port_arbiter

Two-master arbiter that shares one instruction memory port (req/gnt/rvalid protocol) between the core's instruction fetch unit and a second fetch requester, such as a debug program-buffer fetcher or a second core. It sits between the requesters' `instr_*` ports and the instruction memory or cache. It records the owner of every granted, outstanding transaction so that each response returns to the master that issued it. Responses arrive in request order; the arbiter never reorders them.

## Interface
- `RDATA_WIDTH`, default 32: width of the read data bus.
- `MAX_OUTSTANDING`, default 2: maximum number of granted transactions still waiting for rvalid. Range 1..4.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-high.
- `m0_req_i` in 1: master 0 request. Master 0 is the core fetch unit.
- `m0_addr_i` in 32: master 0 address. Held stable while `m0_req_i` is high and not granted.
- `m0_gnt_o` out 1: master 0 grant.
- `m0_rvalid_o` out 1: master 0 response valid.
- `m0_rdata_o` out RDATA_WIDTH: master 0 read data.
- `m0_err_o` out 1: master 0 response error (PMP).
- `m1_req_i`, `m1_addr_i`, `m1_gnt_o`, `m1_rvalid_o`, `m1_rdata_o`, `m1_err_o`: master 1, same directions, widths and meaning as master 0.
- `instr_req_o` out 1: request to memory.
- `instr_addr_o` out 32: address to memory.
- `instr_gnt_i` in 1: grant from memory.
- `instr_rvalid_i` in 1: response valid from memory.
- `instr_rdata_i` in RDATA_WIDTH: read data from memory.
- `instr_err_pmp_i` in 1: response error from memory.
- `busy_o` out 1: high while the outstanding count is nonzero.

## Operation
- State:
  - `sel_q`: owner of the current pending request.
  - `lock_q`: high while a presented request is still ungranted.
  - `prio_q`: the next master to favour (round-robin).
  - An ID FIFO of depth `MAX_OUTSTANDING`, 1 bit per entry (the master ID).
  - `cnt_q`: outstanding count, 0..MAX_OUTSTANDING.
- Full: `cnt_q == MAX_OUTSTANDING` blocks all requests.
  - `instr_req_o` = 0.
  - Both gnt outputs = 0.
  - A pop in the same cycle does not unblock; no combinational path exists from rvalid to req.
- Selection when not full and not locked:
  - Only one master requesting: that master wins.
  - Both requesting: the master indicated by `prio_q` wins.
- Lock:
  - If `instr_req_o` is high and `instr_gnt_i` is low, `lock_q` is set and `sel_q` holds the winner.
  - In following cycles the same master stays selected until it is granted.
  - The other master's request cannot pre-empt the locked one.
- Forwarding:
  - `instr_req_o` = selected master's req (masked by full).
  - `instr_addr_o` = selected master's address.
  - `instr_addr_o` = 0 when no master is selected.
- Grant:
  - `mX_gnt_o` = `instr_gnt_i` AND (X selected) AND `instr_req_o`.
  - On grant: push X into the FIFO, clear the lock, and set `prio_q` to the other master.
- Response:
  - On `instr_rvalid_i` with `cnt_q > 0`: pop the FIFO head H and assert `mH_rvalid_o`.
  - `mX_rdata_o` and `mX_err_o` are driven from `instr_rdata_i` and `instr_err_pmp_i` for both masters. Only rvalid is routed.
- Push and pop in the same cycle: `cnt_q` is unchanged and the FIFO pointers wrap modulo `MAX_OUTSTANDING`.
- A stray `instr_rvalid_i` while `cnt_q == 0` is dropped. No master sees rvalid, and state is unchanged.
- Either master withdrawing `req` while locked is a protocol violation. Behaviour is undefined, and the bench flags it with an assertion.

## Timing
- Request, address and grant paths are combinational: zero added latency.
- Response routing is combinational from `instr_rvalid_i` and the FIFO head.
- Reset (`rst` high at a clock edge):
  - `cnt_q` = 0, FIFO pointers = 0, `lock_q` = 0, `prio_q` = master 0.
  - All outputs read 0 in the following cycle.
  - Responses to transactions issued before the reset are discarded under the stray-rvalid rule.
- A grant in cycle N makes the matching rvalid eligible from cycle N+1.

## Configuration
- `RISCV_INSTR_ARB_RR_EN`
  - Defined: round-robin arbitration as described under Operation.
  - Undefined: fixed priority. Master 0 always wins when both request, `prio_q` is removed, and the lock still applies.

## Structure
- `riscv_defines` gains:
  - `typedef enum logic {INSTR_ARB_M0, INSTR_ARB_M1} instr_arb_id_e`.
  - `localparam INSTR_ARB_MAX_OUTSTANDING = 2`.
- Sub-module `riscv_instr_arb_id_fifo`:
  - Parameterised-depth FIFO of `instr_arb_id_e` entries.
  - Ports: push, pop, full, empty, head.
  - Synchronous active-high reset.

## Test plan
- Master 0 alone issues 3 back-to-back requests with gnt tied high and rvalid 1 cycle later, `MAX_OUTSTANDING`=2 → the third gnt is held until the first rvalid returns. All rdata (0xA0, 0xA4, 0xA8) appears only on `m0_rvalid_o`.
- Both masters request continuously with gnt tied high (RR_EN defined) → grants alternate M0, M1, M0, M1, and rvalids route in the same order. With RR_EN undefined, M1 is never granted.
- M1 requests, gnt is withheld for 3 cycles, then M0 also requests → `instr_addr_o` stays at M1's address 0x1000 until granted. M0 is granted next.
- Push and pop in the same cycle at `cnt_q`=1 → `cnt_q` stays 1, busy_o stays 1, and the FIFO head advances correctly across wrap-around.
- `rst` asserted with 2 transactions outstanding, then 2 rvalids arrive → neither master sees rvalid, `busy_o`=0, and the next M0 request is granted normally.
- Stray `instr_rvalid_i` after reset with an empty FIFO → no `mX_rvalid_o` is asserted and `cnt_q` remains 0.

Source files
------------

// File: rtl/riscv_instr_port_arbiter_pkg.sv
// Shared types and constants for the two-master instruction port arbiter.
//
// Contents:
//   instr_arb_id_e            - master ID stored per outstanding transaction
//   INSTR_ARB_MAX_OUTSTANDING - default depth of the outstanding-ID FIFO
//   instr_arb_other()         - returns the opposite master ID
package riscv_instr_port_arbiter_pkg;

    typedef enum logic {
        INSTR_ARB_M0 = 1'b0,
        INSTR_ARB_M1 = 1'b1
    } instr_arb_id_e;

    localparam int unsigned INSTR_ARB_MAX_OUTSTANDING = 2;

    function automatic instr_arb_id_e instr_arb_other(input instr_arb_id_e id);
        return (id == INSTR_ARB_M0) ? INSTR_ARB_M1 : INSTR_ARB_M0;
    endfunction

endpackage

// File: rtl/riscv_instr_arb_id_fifo.sv
// FIFO of master IDs, one entry per granted transaction awaiting rvalid.
//
// Ports:
//   clk, rst - clock, synchronous active-high reset (clears pointers and count)
//   push     - write push_id at the tail (ignored while full)
//   push_id  - master ID to record
//   pop      - drop the head entry (ignored while empty)
//   full     - DEPTH entries held
//   empty    - no entries held
//   head     - oldest entry (owner of the next response)
module riscv_instr_arb_id_fifo
    import riscv_instr_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = INSTR_ARB_MAX_OUTSTANDING
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  instr_arb_id_e push_id,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output instr_arb_id_e head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    instr_arb_id_e    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one req/gnt/rvalid instruction memory port between two fetch masters.
// Each granted transaction's owner is queued so in-order responses route back
// to the master that issued them.
//
// Build option: define RISCV_INSTR_ARB_RR_EN for round-robin arbitration;
// otherwise master 0 has fixed priority when both request.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   mX_req_i / mX_addr_i          - master X request and address (X = 0, 1)
//   mX_gnt_o                      - master X grant
//   mX_rvalid_o                   - master X response valid
//   mX_rdata_o / mX_err_o         - response data / PMP error (broadcast)
//   instr_req_o / instr_addr_o    - request and address to memory
//   instr_gnt_i                   - grant from memory
//   instr_rvalid_i / instr_rdata_i / instr_err_pmp_i - response from memory
//   busy_o                        - transactions outstanding
module riscv_instr_port_arbiter
    import riscv_instr_port_arbiter_pkg::*;
#(
    parameter int unsigned RDATA_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = INSTR_ARB_MAX_OUTSTANDING
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req_i,
    input  logic [31:0]            m0_addr_i,
    output logic                   m0_gnt_o,
    output logic                   m0_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m0_rdata_o,
    output logic                   m0_err_o,
    input  logic                   m1_req_i,
    input  logic [31:0]            m1_addr_i,
    output logic                   m1_gnt_o,
    output logic                   m1_rvalid_o,
    output logic [RDATA_WIDTH-1:0] m1_rdata_o,
    output logic                   m1_err_o,
    output logic                   instr_req_o,
    output logic [31:0]            instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
    input  logic                   instr_err_pmp_i,
    output logic                   busy_o
);

    logic          lock_q;
    instr_arb_id_e sel_q;
`ifdef RISCV_INSTR_ARB_RR_EN
    instr_arb_id_e prio_q;
`endif

    instr_arb_id_e sel;
    logic          sel_valid;
    logic          sel_req;
    logic          grant;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    instr_arb_id_e fifo_head;

    // A locked master keeps the port until granted; otherwise arbitrate.
    always_comb begin
        sel       = INSTR_ARB_M0;
        sel_valid = 1'b0;
        if (lock_q) begin
            sel       = sel_q;
            sel_valid = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel_valid = 1'b1;
`ifdef RISCV_INSTR_ARB_RR_EN
            sel       = prio_q;
`else
            sel       = INSTR_ARB_M0;
`endif
        end else if (m0_req_i) begin
            sel       = INSTR_ARB_M0;
            sel_valid = 1'b1;
        end else if (m1_req_i) begin
            sel       = INSTR_ARB_M1;
            sel_valid = 1'b1;
        end
    end

    assign sel_req = (sel == INSTR_ARB_M1) ? m1_req_i : m0_req_i;

    // Full uses the registered count only, so rvalid never reaches req.
    assign instr_req_o  = sel_valid & sel_req & ~fifo_full;
    assign instr_addr_o = !sel_valid             ? 32'h0     :
                          (sel == INSTR_ARB_M1)  ? m1_addr_i : m0_addr_i;

    assign grant    = instr_req_o & instr_gnt_i;
    assign m0_gnt_o = grant & (sel == INSTR_ARB_M0);
    assign m1_gnt_o = grant & (sel == INSTR_ARB_M1);

    // Stray rvalid with nothing outstanding is dropped here.
    assign pop         = instr_rvalid_i & ~fifo_empty;
    assign m0_rvalid_o = pop & (fifo_head == INSTR_ARB_M0);
    assign m1_rvalid_o = pop & (fifo_head == INSTR_ARB_M1);

    assign m0_rdata_o = instr_rdata_i;
    assign m1_rdata_o = instr_rdata_i;
    assign m0_err_o   = instr_err_pmp_i;
    assign m1_err_o   = instr_err_pmp_i;

    assign busy_o = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            sel_q  <= INSTR_ARB_M0;
`ifdef RISCV_INSTR_ARB_RR_EN
            prio_q <= INSTR_ARB_M0;
`endif
        end else begin
            if (instr_req_o && !instr_gnt_i) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else if (grant) begin
                lock_q <= 1'b0;
            end
`ifdef RISCV_INSTR_ARB_RR_EN
            if (grant) begin
                prio_q <= instr_arb_other(sel);
            end
`endif
        end
    end

    riscv_instr_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant),
        .push_id (sel),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Self-checking bench for riscv_instr_port_arbiter (defaults: 32-bit data,
// two outstanding). Per-cycle vectors give inputs and expected outputs; a
// queue tracks expected owner/data of each granted request for the responses.
module tb_riscv_instr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        instr_req_o, busy_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_pmp_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;

    always #5 clk = ~clk;

    riscv_instr_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req_i        (m0_req_i),
        .m0_addr_i       (m0_addr_i),
        .m0_gnt_o        (m0_gnt_o),
        .m0_rvalid_o     (m0_rvalid_o),
        .m0_rdata_o      (m0_rdata_o),
        .m0_err_o        (m0_err_o),
        .m1_req_i        (m1_req_i),
        .m1_addr_i       (m1_addr_i),
        .m1_gnt_o        (m1_gnt_o),
        .m1_rvalid_o     (m1_rvalid_o),
        .m1_rdata_o      (m1_rdata_o),
        .m1_err_o        (m1_err_o),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_pmp_i (instr_err_pmp_i),
        .busy_o          (busy_o)
    );

    // A request presented and not granted must still be presented next cycle.
    property p_lock_hold;
        @(posedge clk) disable iff (rst) (instr_req_o && !instr_gnt_i) |=> instr_req_o;
    endproperty
    a_lock_hold: assert property (p_lock_hold)
        else $error("FAIL lock_hold: instr_req_o=%0b, required 1", instr_req_o);

    typedef struct {
        string       tag;
        logic        rst;
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [5:0]  eo;  // {req, gnt0, gnt1, rvalid0, rvalid1, busy}
        logic [31:0] ea;
        logic        ca;  // compare instr_addr_o
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic add(input string tag, input logic rs, input logic r0, input logic [31:0] a0,
                       input logic r1, input logic [31:0] a1, input logic g, input logic rv,
                       input logic [31:0] rd, input logic [5:0] eo, input logic [31:0] ea,
                       input logic ca);
        vec_t v;
        v.tag = tag; v.rst = rs; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.g = g; v.rv = rv; v.rd = rd; v.eo = eo; v.ea = ea; v.ca = ca;
        vecs.push_back(v);
    endtask

    task automatic idle(input string tag, input logic rs);
        add(tag, rs, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1);
    endtask

    initial begin
        logic [5:0] got;
        sb_t        e;
        logic [31:0] rdat;

        // Reset state
        idle("rst", 1);
        idle("reset_idle", 0);
        // M0 alone, three requests; third blocked while full
        add("a_g0",    0, 1, 32'hA0, 0, 0, 1, 0, 0,      6'b110000, 32'hA0, 1);
        add("a_g1",    0, 1, 32'hA4, 0, 0, 1, 0, 0,      6'b110001, 32'hA4, 1);
        add("a_full",  0, 1, 32'hA8, 0, 0, 1, 1, 32'hA0, 6'b000101, 0,      0);
        add("a_pp",    0, 1, 32'hA8, 0, 0, 1, 1, 32'hA4, 6'b110101, 32'hA8, 1);
        add("a_last",  0, 0, 0,      0, 0, 1, 1, 32'hA8, 6'b000101, 0,      1);
        idle("a_idle", 0);
        // Both masters continuously
        idle("b_rst", 1);
        idle("b_idle0", 0);
`ifdef RISCV_INSTR_ARB_RR_EN
        add("b1", 0, 1, 32'h100, 1, 32'h200, 1, 0, 0,       6'b110000, 32'h100, 1);
        add("b2", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 6'b101101, 32'h200, 1);
        add("b3", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h200, 6'b110011, 32'h100, 1);
        add("b4", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 6'b101101, 32'h200, 1);
        add("b5", 0, 0, 0,       0, 0,       1, 1, 32'h200, 6'b000011, 0,       1);
`else
        add("b1", 0, 1, 32'h100, 1, 32'h200, 1, 0, 0,       6'b110000, 32'h100, 1);
        add("b2", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 6'b110101, 32'h100, 1);
        add("b3", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 6'b110101, 32'h100, 1);
        add("b4", 0, 1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 6'b110101, 32'h100, 1);
        add("b5", 0, 0, 0,       0, 0,       1, 1, 32'h100, 6'b000101, 0,       1);
`endif
        idle("b_idle1", 0);
        // M1 locked while gnt withheld, M0 arrives late
        add("c1", 0, 0, 0,        1, 32'h1000, 0, 0, 0,        6'b100000, 32'h1000, 1);
        add("c2", 0, 0, 0,        1, 32'h1000, 0, 0, 0,        6'b100000, 32'h1000, 1);
        add("c3", 0, 0, 0,        1, 32'h1000, 0, 0, 0,        6'b100000, 32'h1000, 1);
        add("c4", 0, 1, 32'h2000, 1, 32'h1000, 0, 0, 0,        6'b100000, 32'h1000, 1);
        add("c5", 0, 1, 32'h2000, 1, 32'h1000, 1, 0, 0,        6'b101000, 32'h1000, 1);
        add("c6", 0, 1, 32'h2000, 1, 32'h1004, 1, 1, 32'h1000, 6'b110011, 32'h2000, 1);
        add("c7", 0, 0, 0,        0, 0,        1, 1, 32'h2000, 6'b000101, 0,        1);
        idle("c_idle", 0);
        // Reset with two outstanding, then stray responses
        add("d1",  0, 1, 32'h300, 0, 0, 1, 0, 0,       6'b110000, 32'h300, 1);
        add("d2",  0, 1, 32'h304, 0, 0, 1, 0, 0,       6'b110001, 32'h304, 1);
        idle("d_rst", 1);
        add("d_stray0", 0, 0, 0,  0, 0, 0, 1, 32'h300, 6'b000000, 0,       1);
        add("d_stray1", 0, 0, 0,  0, 0, 0, 1, 32'h304, 6'b000000, 0,       1);
        add("d_g",  0, 1, 32'h400, 0, 0, 1, 0, 0,       6'b110000, 32'h400, 1);
        add("d_rv", 0, 0, 0,       0, 0, 0, 1, 32'h400, 6'b000101, 0,       1);
        idle("d_idle", 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst            = vecs[i].rst;
            m0_req_i       = vecs[i].r0;
            m0_addr_i      = vecs[i].a0;
            m1_req_i       = vecs[i].r1;
            m1_addr_i      = vecs[i].a1;
            instr_gnt_i    = vecs[i].g;
            instr_rvalid_i = vecs[i].rv;
            instr_rdata_i  = vecs[i].rd;
            if (vecs[i].rst) sb_q.delete();
            @(negedge clk);
            if (vecs[i].rst) continue;

            got = {instr_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o};
            n_chk++;
            if (got !== vecs[i].eo || (vecs[i].ca && instr_addr_o !== vecs[i].ea))
                $display("FAIL %s: {req,g0,g1,v0,v1,busy}=%b addr=%h, required %b addr=%h",
                         vecs[i].tag, got, instr_addr_o, vecs[i].eo, vecs[i].ea);
            else
                n_pass++;

            // Response routing against the owner queue
            if (m0_rvalid_o === 1'b1 || m1_rvalid_o === 1'b1) begin
                n_chk++;
                rdat = m1_rvalid_o ? m1_rdata_o : m0_rdata_o;
                if (sb_q.size() == 0) begin
                    $display("FAIL %s_resp: rvalid {m0,m1}=%b%b, required none",
                             vecs[i].tag, m0_rvalid_o, m1_rvalid_o);
                end else begin
                    e = sb_q.pop_front();
                    if ({m0_rvalid_o, m1_rvalid_o} !== (e.id ? 2'b01 : 2'b10) || rdat !== e.data)
                        $display("FAIL %s_resp: rvalid {m0,m1}=%b%b data=%h, required m%0d data=%h",
                                 vecs[i].tag, m0_rvalid_o, m1_rvalid_o, rdat, e.id, e.data);
                    else
                        n_pass++;
                end
            end

            // Record expected owner of this cycle's grant
            if (vecs[i].eo[4]) sb_q.push_back('{id: 1'b0, data: vecs[i].ea});
            if (vecs[i].eo[3]) sb_q.push_back('{id: 1'b1, data: vecs[i].ea});
        end

        n_chk++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
